// File: rtl/button_event_pkg.sv
// Shared constants for the button event classifier: FSM state encoding,
// default timing thresholds and a small helper for sizing the counter.
package button_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOWN1 = 3'd1,
    ST_WAIT2 = 3'd2,
    ST_DOWN2 = 3'd3,
    ST_LONG  = 3'd4
  } state_e;

  // 1 s hold and 300 ms inter-click gap at 50 MHz
  localparam int unsigned LONG_CYC_DEF = 50_000_000;
  localparam int unsigned GAP_CYC_DEF  = 15_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_edge.sv
// Edge detector for the debounced button level. Edges are masked until the
// first clock after reset so a button held through reset reports no press.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic held_o,
  output logic rise_o,
  output logic fall_o
);

  logic btn_q, btn_d;
  logic armed_q, armed_d;

  always_comb begin
    btn_d   = btn_i;
    armed_d = 1'b1;
    rise_o  = armed_q & btn_i & ~btn_q;
    fall_o  = armed_q & ~btn_i & btn_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn_d;
      armed_q <= armed_d;
    end
  end

  assign held_o = btn_q;

endmodule

// File: rtl/button_event.sv
// Classifies a debounced button level into one-cycle press, release, click,
// double-click and long-press events. All event outputs are registered.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYC = LONG_CYC_DEF,
  parameter int unsigned GAP_CYC  = GAP_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dbl_click_o,
  output logic long_o
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_CYC, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             dbl_q, dbl_d;
  logic             long_q, long_d;

  btn_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_i),
    .held_o (held_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  // A fall always beats a threshold hit in the same cycle, and a rise beats
  // gap expiry, so checking the edge first in each state gives both rules.
  always_comb begin
    state_d   = state_q;
    click_d   = 1'b0;
    dbl_d     = 1'b0;
    long_d    = 1'b0;
    press_d   = rise;
    release_d = fall;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_DOWN1;
      end
      ST_DOWN1: begin
        if (fall) begin
          state_d = ST_WAIT2;
        end else if (cnt_q == LONG_END) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_WAIT2: begin
        if (rise) begin
          state_d = ST_DOWN2;
        end else if (cnt_q == GAP_END) begin
          click_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DOWN2: begin
        if (fall) begin
          dbl_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == LONG_END) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_LONG: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dbl_q     <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dbl_q     <= dbl_d;
      long_q    <= long_d;
    end
  end

  assign press_o     = press_q;
  assign release_o   = release_q;
  assign click_o     = click_q;
  assign dbl_click_o = dbl_q;
  assign long_o      = long_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed gesture scenarios plus random level
// sequences, all compared cycle by cycle against a timestamp-based model.
module tb_button_event;

  localparam int LONG = 100;
  localparam int GAP  = 40;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_i;
  logic held_o, press_o, release_o, click_o, dbl_click_o, long_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: gesture tracked by timestamps of the latest press/release
  int   k;
  logic prev;
  int   down_since, up_since, presses;
  bit   long_done;
  logic [5:0] exp_v;

  button_event #(.LONG_CYC(LONG), .GAP_CYC(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_i       (btn_i),
    .held_o      (held_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .click_o     (click_o),
    .dbl_click_o (dbl_click_o),
    .long_o      (long_o)
  );

  always #10 clk = ~clk;

  task automatic gesture_clear();
    down_since = -1;
    up_since   = -1;
    presses    = 0;
    long_done  = 0;
  endtask

  task automatic model_reset();
    k    = 0;
    prev = 1'b0;
    gesture_clear();
    exp_v = '0;
  endtask

  // Called once per sampling clock edge with the level sampled at that edge.
  task automatic model_edge(input logic b);
    logic rise, fall, ev_click, ev_dbl, ev_long;
    k++;
    rise = (k >= 2) && b && !prev;
    fall = (k >= 2) && !b && prev;
    prev = b;
    ev_click = 0; ev_dbl = 0; ev_long = 0;
    if (fall && down_since >= 0) begin
      if (long_done) gesture_clear();
      else if (presses == 2) begin ev_dbl = 1; gesture_clear(); end
      else begin up_since = k; down_since = -1; end
    end else if (rise) begin
      presses    = (up_since >= 0) ? 2 : 1;
      down_since = k;
      up_since   = -1;
    end else if (down_since >= 0 && !long_done && (k - down_since) == LONG) begin
      ev_long = 1;
      long_done = 1;
    end else if (up_since >= 0 && (k - up_since) == GAP) begin
      ev_click = 1;
      gesture_clear();
    end
    exp_v = {b, rise, fall, ev_click, ev_dbl, ev_long};
  endtask

  // Entered and left at a negedge; drives one level for one clock.
  task automatic step(input logic b, output logic [5:0] obs, output logic [5:0] ex);
    btn_i = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    obs = {held_o, press_o, release_o, click_o, dbl_click_o, long_o};
    ex  = exp_v;
  endtask

  task automatic test_reset();
    logic [5:0] obs, ex;
    int n_press = 0, n_rel = 0, n_ev = 0;
    logic held_seen = 1'b0;
    rst_n = 1'b0;
    btn_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({held_o, press_o, release_o, click_o, dbl_click_o, long_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {held_o, press_o, release_o, click_o, dbl_click_o, long_o}, 6'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 110; i++) begin
      step(i < 50, obs, ex);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL held_through_reset cyc=%0d got=%b exp=%b", k, obs, ex);
      end
      if (i == 49) held_seen = obs[5];
      n_press += obs[4];
      n_rel   += obs[3];
      n_ev    += obs[2] + obs[1] + obs[0];
    end
    vectors++;
    if (n_press !== 0 || n_rel !== 1 || n_ev !== 0 || held_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL held_through_reset_counts got press=%0d rel=%0d ev=%0d held=%b exp 0/1/0/1",
               n_press, n_rel, n_ev, held_seen);
    end
  endtask

  task automatic test_click();
    logic [5:0] obs, ex;
    int rel_at = -1, click_at = -1, n_click = 0, n_press = 0;
    for (int i = 0; i < 70; i++) begin
      step(i < 10, obs, ex);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL single_click cyc=%0d got=%b exp=%b", k, obs, ex);
      end
      n_press += obs[4];
      if (obs[3]) rel_at = k;
      if (obs[2]) begin n_click++; click_at = k; end
    end
    vectors++;
    if (n_press !== 1 || n_click !== 1 || (click_at - rel_at) !== GAP) begin
      miscompares++;
      $display("FAIL single_click_timing got press=%0d click=%0d delay=%0d exp 1/1/%0d",
               n_press, n_click, click_at - rel_at, GAP);
    end
  endtask

  // Shared shape for the two double-click scenarios: high, low gap_len, high, low.
  task automatic test_double(input int gap_len);
    logic [5:0] obs, ex;
    int n_press = 0, n_rel = 0, n_click = 0, n_dbl = 0, dbl_at = -1, rel2_at = -1;
    for (int i = 0; i < 20 + gap_len + 60; i++) begin
      step((i < 10) || (i >= 10 + gap_len && i < 20 + gap_len), obs, ex);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL double_click gap=%0d cyc=%0d got=%b exp=%b", gap_len, k, obs, ex);
      end
      n_press += obs[4];
      if (obs[3]) begin n_rel++; if (n_rel == 2) rel2_at = k; end
      n_click += obs[2];
      if (obs[1]) begin n_dbl++; dbl_at = k; end
    end
    vectors++;
    if (n_press !== 2 || n_rel !== 2 || n_click !== 0 || n_dbl !== 1 || dbl_at !== rel2_at) begin
      miscompares++;
      $display("FAIL double_click_counts gap=%0d got p=%0d r=%0d c=%0d d=%0d at=%0d/%0d exp 2/2/0/1 same",
               gap_len, n_press, n_rel, n_click, n_dbl, dbl_at, rel2_at);
    end
  endtask

  task automatic test_long();
    logic [5:0] obs, ex;
    int press_at = -1, long_at = -1, n_long = 0, n_rel = 0, n_other = 0;
    for (int i = 0; i < 210; i++) begin
      step(i < 150, obs, ex);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL long_press cyc=%0d got=%b exp=%b", k, obs, ex);
      end
      if (obs[4]) press_at = k;
      if (obs[0]) begin n_long++; long_at = k; end
      n_rel   += obs[3];
      n_other += obs[2] + obs[1];
    end
    vectors++;
    if (n_long !== 1 || (long_at - press_at) !== LONG || n_rel !== 1 || n_other !== 0) begin
      miscompares++;
      $display("FAIL long_press_counts got long=%0d delay=%0d rel=%0d other=%0d exp 1/%0d/1/0",
               n_long, long_at - press_at, n_rel, n_other, LONG);
    end
  endtask

  task automatic test_reset_mid_gesture();
    logic [5:0] obs, ex;
    int n_press = 0, n_ev = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, obs, ex);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL pre_reset cyc=%0d got=%b exp=%b", k, obs, ex);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({held_o, press_o, release_o, click_o, dbl_click_o, long_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL async_reset got=%b exp=%b",
               {held_o, press_o, release_o, click_o, dbl_click_o, long_o}, 6'b0);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({held_o, press_o, release_o, click_o, dbl_click_o, long_o} !== 6'b0) begin
        miscompares++;
        $display("FAIL in_reset cyc=%0d got=%b exp=%b", i,
                 {held_o, press_o, release_o, click_o, dbl_click_o, long_o}, 6'b0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 180; i++) begin
      step(i < 120, obs, ex);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", k, obs, ex);
      end
      n_press += obs[4];
      n_ev    += obs[2] + obs[1] + obs[0];
    end
    vectors++;
    if (n_press !== 0 || n_ev !== 0) begin
      miscompares++;
      $display("FAIL post_reset_counts got press=%0d ev=%0d exp 0/0", n_press, n_ev);
    end
  endtask

  task automatic test_random();
    logic [5:0] obs, ex;
    logic lvl = 1'b0;
    int   len;
    int   edges[6] = '{GAP - 1, GAP, GAP + 1, LONG - 1, LONG, LONG + 1};
    for (int s = 0; s < 160; s++) begin
      lvl = ~lvl;
      case ($urandom_range(0, 3))
        0:       len = edges[$urandom_range(0, 5)];
        1:       len = $urandom_range(1, 5);
        default: len = $urandom_range(1, 130);
      endcase
      for (int i = 0; i < len; i++) begin
        step(lvl, obs, ex);
        vectors++;
        if (obs !== ex) begin
          miscompares++;
          $display("FAIL random seg=%0d cyc=%0d got=%b exp=%b", s, k, obs, ex);
        end
      end
    end
  endtask

  initial begin
    btn_i = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_click();
    test_double(20);
    test_long();
    test_double(GAP);
    test_reset_mid_gesture();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
